hv_reg_access_arb: RTL and testbench
====================================

HV_REG_ACCESS_ARB -- requirements
Module: hv_reg_access_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requester channels (2..8).
REQ-002 SHALL have parameter REG_AW, default 7, register address width.
REQ-003 SHALL have parameter REG_DW, default 8, register data width.
REQ-004 SHALL have parameter REG_CRC_W, default 8, register CRC width.
REQ-005 SHALL have parameter ARB_MODE, default 0, where 0 = fixed priority (index 0 highest) and 1 = round-robin.
REQ-006 SHALL have parameter TMO_CYC, default 64, cycles waited in WAIT before an access is declared timed out (>=2).
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 SHALL have ports:
- i_clk in 1, clock.
- i_rst in 1, synchronous active-high reset.
- i_req_rd in NUM_REQ, per-channel read request level.
- i_req_wr in NUM_REQ, per-channel write request level.
- i_req_addr in NUM_REQ*REG_AW, channel k at slice [k*REG_AW +: REG_AW].
- i_req_wdata in NUM_REQ*REG_DW, per-channel write data, packed likewise.
- i_req_wcrc in NUM_REQ*REG_CRC_W, per-channel write CRC, packed likewise.
- o_req_ack out NUM_REQ, one-hot completion pulse.
- o_req_err out NUM_REQ, one-hot timeout pulse.
- o_req_rdata out REG_DW, read data, valid with o_req_ack.
- o_req_rcrc out REG_CRC_W, read CRC, valid with o_req_ack.
- o_reg_ren out 1, register-file read strobe.
- o_reg_wen out 1, register-file write strobe.
- o_reg_addr out REG_AW, register-file address.
- o_reg_wdata out REG_DW, register-file write data.
- o_reg_wcrc out REG_CRC_W, register-file write CRC.
- i_reg_wack in 1, register-file write acknowledge.
- i_reg_rack in 1, register-file read acknowledge.
- i_reg_rdata in REG_DW, register-file read data.
- i_reg_rcrc in REG_CRC_W, register-file read CRC.
- o_busy out 1, high when the FSM is not in IDLE.
- o_gnt_idx out $clog2(NUM_REQ), index of the current or last granted channel.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-010 In IDLE, channel k SHALL be eligible when i_req_rd[k] or i_req_wr[k] is high.
REQ-011 In IDLE, if any channel is eligible, the block SHALL grant exactly one channel, capture its addr, wdata, wcrc and op, and go to WAIT.
REQ-012 Fixed mode SHALL grant the lowest eligible index.
REQ-013 Round-robin mode SHALL search from (last granted index + 1) mod NUM_REQ upward with wrap-around; after reset, last granted index SHALL be NUM_REQ-1.
REQ-014 If a channel has rd and wr high together, the block SHALL perform the write.
REQ-015 o_reg_ren or o_reg_wen SHALL pulse high for exactly one cycle, in the first WAIT cycle (one cycle after grant), with o_reg_addr, o_reg_wdata and o_reg_wcrc stable from then until the next grant.
REQ-016 In WAIT, a matching ack (i_reg_wack for a write, i_reg_rack for a read) SHALL move the FSM to RESP; a non-matching ack SHALL be ignored.
REQ-017 On a read rack, the block SHALL latch i_reg_rdata and i_reg_rcrc into o_req_rdata and o_req_rcrc.
REQ-018 In RESP, o_req_ack[gnt] SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE; latency from reg ack to o_req_ack SHALL be 1 cycle.
REQ-019 The WAIT cycle counter SHALL start at 0 on WAIT entry and increment each cycle; on reaching TMO_CYC-1 with no matching ack, o_req_err[gnt] SHALL pulse one cycle and the FSM SHALL go to IDLE.
REQ-020 If a matching ack coincides with the timeout terminal count, the ack SHALL win: RESP is entered and no err is raised.
REQ-021 An ack arriving in IDLE or RESP SHALL be ignored.
REQ-022 Requesters SHALL hold req until ack or err and drop it on the following cycle; a request dropped before grant SHALL not be served.
REQ-023 Round-robin pointer SHALL update on grant.
REQ-024 o_req_ack and o_req_err SHALL never both be high, and never more than one bit of each SHALL be high.
REQ-025 Minimum spacing between back-to-back grants SHALL be 3 cycles (IDLE, WAIT, RESP).

Reset
REQ-026 While i_rst is high at a clock edge, the FSM SHALL go to IDLE, and all strobes, acks, errs and o_busy SHALL be 0.
REQ-027 While i_rst is high at a clock edge, o_reg_addr, o_reg_wdata, o_reg_wcrc, o_req_rdata, o_req_rcrc, o_gnt_idx and the counter SHALL be 0, and the RR pointer SHALL be NUM_REQ-1.
REQ-028 Reset asserted mid-WAIT SHALL abort the access with no ack or err; a late reg ack after reset release SHALL be ignored.

Verification
REQ-029 Bench SHALL cover: ch1 write addr 0x12 data 0xA5, wack 2 cycles after wen -> o_reg_wen one pulse, addr 0x12, o_req_ack[1] one cycle after wack.
REQ-030 Bench SHALL cover: ch0 read, rack with rdata 0x3C -> o_req_ack[0] with o_req_rdata=0x3C.
REQ-031 Bench SHALL cover: ARB_MODE=1, all 3 channels requesting continuously -> grant order 0,1,2,0; in ARB_MODE=0 -> order 0,0,...
REQ-032 Bench SHALL cover: TMO_CYC=8, no ack -> o_req_err[gnt] 8 cycles after WAIT entry, FSM in IDLE next cycle.
REQ-033 Bench SHALL cover: ack exactly at the terminal cycle -> ack and no err; rack while waiting a write -> ignored, then timeout.
REQ-034 Bench SHALL cover: reset asserted during WAIT then a rack -> no o_req_ack, o_busy=0.

Source files
------------

// File: rtl/hv_reg_access_arb.sv
// Register-access arbiter: grants one of NUM_REQ requesters at a time to a single
// register-file port. Each access waits for an ack and is timed out after TMO_CYC cycles.
module hv_reg_access_arb #(
    parameter int NUM_REQ   = 3,
    parameter int REG_AW    = 7,
    parameter int REG_DW    = 8,
    parameter int REG_CRC_W = 8,
    parameter int ARB_MODE  = 0,
    parameter int TMO_CYC   = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_rd,
    input  logic [NUM_REQ-1:0]             i_req_wr,
    input  logic [NUM_REQ*REG_AW-1:0]      i_req_addr,
    input  logic [NUM_REQ*REG_DW-1:0]      i_req_wdata,
    input  logic [NUM_REQ*REG_CRC_W-1:0]   i_req_wcrc,
    output logic [NUM_REQ-1:0]             o_req_ack,
    output logic [NUM_REQ-1:0]             o_req_err,
    output logic [REG_DW-1:0]              o_req_rdata,
    output logic [REG_CRC_W-1:0]           o_req_rcrc,
    output logic                           o_reg_ren,
    output logic                           o_reg_wen,
    output logic [REG_AW-1:0]              o_reg_addr,
    output logic [REG_DW-1:0]              o_reg_wdata,
    output logic [REG_CRC_W-1:0]           o_reg_wcrc,
    input  logic                           i_reg_wack,
    input  logic                           i_reg_rack,
    input  logic [REG_DW-1:0]              i_reg_rdata,
    input  logic [REG_CRC_W-1:0]           i_reg_rcrc,
    output logic                           o_busy,
    output logic [$clog2(NUM_REQ)-1:0]     o_gnt_idx
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] CNT_TC = CW'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GW-1:0]        gnt_q, gnt_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 op_wr_q, op_wr_d;
    logic                 ren_q, ren_d;
    logic                 wen_q, wen_d;
    logic [REG_AW-1:0]    addr_q, addr_d;
    logic [REG_DW-1:0]    wdata_q, wdata_d;
    logic [REG_CRC_W-1:0] wcrc_q, wcrc_d;
    logic [REG_DW-1:0]    rdata_q, rdata_d;
    logic [REG_CRC_W-1:0] rcrc_q, rcrc_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   err_q, err_d;

    logic [NUM_REQ-1:0]   elig;
    logic                 match;
    int                   pick;
    int                   idx;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wcrc_d   = wcrc_q;
        rdata_d  = rdata_q;
        rcrc_d   = rcrc_q;
        ren_d    = 1'b0;
        wen_d    = 1'b0;
        ack_d    = '0;
        err_d    = '0;
        pick     = 0;
        idx      = 0;

        elig  = i_req_rd | i_req_wr;
        match = op_wr_q ? i_reg_wack : i_reg_rack;

        // Descending scans so the last hit is the highest-priority candidate.
        if (ARB_MODE == 1) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + 1 + k) % NUM_REQ;
                if (elig[idx]) pick = idx;
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (elig[k]) pick = k;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A held request is masked in the err cycle so it is not re-served.
                if ((|elig) && !(|err_q)) begin
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    gnt_d    = GW'(pick);
                    rr_ptr_d = GW'(pick);
                    op_wr_d  = i_req_wr[pick];
                    wen_d    = i_req_wr[pick];
                    ren_d    = ~i_req_wr[pick];
                    addr_d   = i_req_addr[pick*REG_AW +: REG_AW];
                    wdata_d  = i_req_wdata[pick*REG_DW +: REG_DW];
                    wcrc_d   = i_req_wcrc[pick*REG_CRC_W +: REG_CRC_W];
                end
            end
            ST_WAIT: begin
                if (match) begin
                    state_d = ST_RESP;
                    ack_d   = NUM_REQ'(1) << gnt_q;
                    if (!op_wr_q) begin
                        rdata_d = i_reg_rdata;
                        rcrc_d  = i_reg_rcrc;
                    end
                end else if (cnt_q == CNT_TC) begin
                    state_d = ST_IDLE;
                    err_d   = NUM_REQ'(1) << gnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= GW'(NUM_REQ - 1);
            op_wr_q  <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wcrc_q   <= '0;
            rdata_q  <= '0;
            rcrc_q   <= '0;
            ack_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            op_wr_q  <= op_wr_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wcrc_q   <= wcrc_d;
            rdata_q  <= rdata_d;
            rcrc_q   <= rcrc_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign o_req_ack   = ack_q;
    assign o_req_err   = err_q;
    assign o_req_rdata = rdata_q;
    assign o_req_rcrc  = rcrc_q;
    assign o_reg_ren   = ren_q;
    assign o_reg_wen   = wen_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_wcrc  = wcrc_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_gnt_idx   = gnt_q;

endmodule

// File: tb/tb_hv_reg_access_arb.sv
// Directed bench for hv_reg_access_arb: a fixed-priority and a round-robin instance share
// stimulus; completions of the fixed instance are checked against a scoreboard queue.
module tb_hv_reg_access_arb;

    localparam int N   = 3;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int CRW = 8;
    localparam int TMO = 8;

    typedef struct {
        bit         is_err;
        int         ch;
        bit         chk_rd;
        logic [7:0] rdata;
        logic [7:0] rcrc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_rd, req_wr;
    logic [N*AW-1:0]  req_addr;
    logic [N*DW-1:0]  req_wdata;
    logic [N*CRW-1:0] req_wcrc;
    logic             reg_wack, reg_rack;
    logic [DW-1:0]    reg_rdata;
    logic [CRW-1:0]   reg_rcrc;

    logic [N-1:0]     f_ack, f_err, r_ack, r_err;
    logic [DW-1:0]    f_rdata, r_rdata, f_wdata, r_wdata;
    logic [CRW-1:0]   f_rcrc, r_rcrc, f_wcrc, r_wcrc;
    logic             f_ren, f_wen, r_ren, r_wen, f_busy, r_busy;
    logic [AW-1:0]    f_addr, r_addr;
    logic [1:0]       f_gnt, r_gnt;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hv_reg_access_arb #(.NUM_REQ(N), .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CRW),
                        .ARB_MODE(0), .TMO_CYC(TMO)) dut_fix (
        .i_clk(clk), .i_rst(rst), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wcrc(req_wcrc),
        .o_req_ack(f_ack), .o_req_err(f_err), .o_req_rdata(f_rdata), .o_req_rcrc(f_rcrc),
        .o_reg_ren(f_ren), .o_reg_wen(f_wen), .o_reg_addr(f_addr), .o_reg_wdata(f_wdata),
        .o_reg_wcrc(f_wcrc), .i_reg_wack(reg_wack), .i_reg_rack(reg_rack),
        .i_reg_rdata(reg_rdata), .i_reg_rcrc(reg_rcrc), .o_busy(f_busy), .o_gnt_idx(f_gnt)
    );

    hv_reg_access_arb #(.NUM_REQ(N), .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CRW),
                        .ARB_MODE(1), .TMO_CYC(TMO)) dut_rr (
        .i_clk(clk), .i_rst(rst), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wcrc(req_wcrc),
        .o_req_ack(r_ack), .o_req_err(r_err), .o_req_rdata(r_rdata), .o_req_rcrc(r_rcrc),
        .o_reg_ren(r_ren), .o_reg_wen(r_wen), .o_reg_addr(r_addr), .o_reg_wdata(r_wdata),
        .o_reg_wcrc(r_wcrc), .i_reg_wack(reg_wack), .i_reg_rack(reg_rack),
        .i_reg_rdata(reg_rdata), .i_reg_rcrc(reg_rcrc), .o_busy(r_busy), .o_gnt_idx(r_gnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the fixed instance reports ack or err; n is the number of cycles taken.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((f_ack | f_err) == '0) && (n < limit));
        if ((f_ack | f_err) == '0) check("done_bound", 32'(|(f_ack | f_err)), 1);
    endtask

    // Scoreboard: every completion pulse of the fixed instance must match the queue head.
    always @(negedge clk) begin
        if (!rst && ((f_ack | f_err) != '0)) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 32'({f_ack, f_err}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ack", 32'(f_ack), e.is_err ? 0 : (1 << e.ch));
                check("sb_err", 32'(f_err), e.is_err ? (1 << e.ch) : 0);
                if (e.chk_rd) begin
                    check("sb_rdata", 32'(f_rdata), 32'(e.rdata));
                    check("sb_rcrc", 32'(f_rcrc), 32'(e.rcrc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_f[4];
        int exp_r[4];
        exp_f = '{0, 0, 0, 0};
        exp_r = '{0, 1, 2, 0};

        rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wcrc = '0;
        reg_wack = 1'b0; reg_rack = 1'b0; reg_rdata = '0; reg_rcrc = '0;
        repeat (3) tick();
        check("rst_busy", 32'(f_busy), 0);
        check("rst_ack_err", 32'({f_ack, f_err}), 0);
        check("rst_strobes", 32'({f_ren, f_wen}), 0);
        check("rst_addr", 32'(f_addr), 0);
        check("rst_gnt", 32'(f_gnt), 0);
        check("rst_rdata", 32'({f_rdata, f_rcrc}), 0);
        check("rst_rr_gnt", 32'(r_gnt), 0);
        rst = 1'b0;
        tick();

        // ch1 write, wack two cycles after the wen pulse.
        req_addr[AW +: AW] = 7'h12; req_wdata[DW +: DW] = 8'hA5; req_wcrc[CRW +: CRW] = 8'h5A;
        req_wr[1] = 1'b1;
        sb.push_back('{is_err: 0, ch: 1, chk_rd: 0, rdata: 8'h00, rcrc: 8'h00});
        tick();
        check("wr_wen", 32'({f_ren, f_wen}), 1);
        check("wr_addr", 32'(f_addr), 32'h12);
        check("wr_wdata", 32'(f_wdata), 32'hA5);
        check("wr_wcrc", 32'(f_wcrc), 32'h5A);
        check("wr_gnt", 32'(f_gnt), 1);
        check("wr_busy", 32'(f_busy), 1);
        tick();
        check("wr_wen_pulse", 32'(f_wen), 0);
        tick();
        reg_wack = 1'b1;
        tick();
        reg_wack = 1'b0;
        check("wr_ack_latency", 32'(f_ack), 32'b010);
        tick();
        req_wr[1] = 1'b0;
        tick();
        check("wr_idle", 32'(f_busy), 0);
        check("wr_addr_hold", 32'(f_addr), 32'h12);

        // ch0 read answered by rack in the ren cycle; data must be latched.
        req_addr[0 +: AW] = 7'h05; req_rd[0] = 1'b1;
        sb.push_back('{is_err: 0, ch: 0, chk_rd: 1, rdata: 8'h3C, rcrc: 8'hC3});
        tick();
        check("rd_ren", 32'({f_ren, f_wen}), 2);
        check("rd_addr", 32'(f_addr), 32'h05);
        reg_rack = 1'b1; reg_rdata = 8'h3C; reg_rcrc = 8'hC3;
        tick();
        reg_rack = 1'b0; reg_rdata = 8'h00; reg_rcrc = 8'h00;
        check("rd_ack", 32'(f_ack), 32'b001);
        check("rd_rdata", 32'(f_rdata), 32'h3C);
        tick();
        req_rd[0] = 1'b0;
        tick();
        check("rd_rdata_hold", 32'(f_rdata), 32'h3C);
        check("rd_idle", 32'(f_busy), 0);

        // ch2 with rd and wr together performs a write; a stray rack is ignored.
        req_addr[2*AW +: AW] = 7'h7F; req_wdata[2*DW +: DW] = 8'hFF;
        req_rd[2] = 1'b1; req_wr[2] = 1'b1;
        sb.push_back('{is_err: 0, ch: 2, chk_rd: 0, rdata: 8'h00, rcrc: 8'h00});
        tick();
        check("rdwr_wen", 32'({f_ren, f_wen}), 1);
        check("rdwr_addr", 32'(f_addr), 32'h7F);
        reg_rack = 1'b1;
        tick();
        reg_rack = 1'b0;
        check("rdwr_rack_ignored", 32'({f_busy, f_ack}), 32'b1000);
        reg_wack = 1'b1;
        tick();
        reg_wack = 1'b0;
        check("rdwr_ack", 32'(f_ack), 32'b100);
        tick();
        req_rd[2] = 1'b0; req_wr[2] = 1'b0;
        tick();

        // ch0 write with no wack (a rack in between is ignored) -> err 8 cycles after WAIT entry.
        req_addr[0 +: AW] = 7'h00; req_wr[0] = 1'b1;
        sb.push_back('{is_err: 1, ch: 0, chk_rd: 0, rdata: 8'h00, rcrc: 8'h00});
        tick();
        tick();
        reg_rack = 1'b1;
        tick();
        reg_rack = 1'b0;
        wait_done(20, n);
        check("tmo_latency", 32'(n + 2), 8);
        check("tmo_err", 32'(f_err), 32'b001);
        check("tmo_idle", 32'(f_busy), 0);
        tick();
        check("tmo_no_regrant", 32'(f_busy), 0);
        req_wr[0] = 1'b0;
        tick();

        // ch1 read with rack exactly at the terminal count: ack wins, no err.
        req_addr[AW +: AW] = 7'h40; req_rd[1] = 1'b1;
        sb.push_back('{is_err: 0, ch: 1, chk_rd: 1, rdata: 8'h81, rcrc: 8'h18});
        tick();
        repeat (7) tick();
        check("tc_still_waiting", 32'({f_busy, f_err}), 32'b1000);
        reg_rack = 1'b1; reg_rdata = 8'h81; reg_rcrc = 8'h18;
        tick();
        reg_rack = 1'b0;
        check("tc_ack", 32'(f_ack), 32'b010);
        check("tc_no_err", 32'(f_err), 0);
        tick();
        req_rd[1] = 1'b0;
        tick();

        // Acks while idle are ignored.
        reg_wack = 1'b1; reg_rack = 1'b1;
        repeat (3) tick();
        reg_wack = 1'b0; reg_rack = 1'b0;
        check("idle_ack_ignored", 32'({f_busy, f_ack, f_err}), 0);

        // Reset during WAIT aborts; a late rack afterwards does nothing.
        req_addr[2*AW +: AW] = 7'h33; req_rd[2] = 1'b1;
        tick();
        check("rstw_busy", 32'(f_busy), 1);
        rst = 1'b1; req_rd[2] = 1'b0;
        tick();
        check("rstw_busy_clr", 32'(f_busy), 0);
        check("rstw_outputs", 32'({f_ren, f_wen, f_addr, f_gnt}), 0);
        rst = 1'b0; reg_rack = 1'b1; reg_rdata = 8'h99;
        tick();
        reg_rack = 1'b0;
        repeat (2) tick();
        check("rstw_no_ack", 32'({f_busy, f_ack, f_err}), 0);
        check("rstw_rdata", 32'(f_rdata), 0);

        // All three channels writing continuously: fixed 0,0,0,0; round-robin 0,1,2,0.
        req_wr = 3'b111;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{is_err: 0, ch: exp_f[i], chk_rd: 0, rdata: 8'h00, rcrc: 8'h00});
            n = 0;
            do begin
                tick();
                n++;
            end while (!f_wen && n < 10);
            check($sformatf("arb_wen_%0d", i), 32'({f_wen, r_wen}), 3);
            check($sformatf("fix_gnt_%0d", i), 32'(f_gnt), exp_f[i]);
            check($sformatf("rr_gnt_%0d", i), 32'(r_gnt), exp_r[i]);
            reg_wack = 1'b1;
            tick();
            reg_wack = 1'b0;
            check($sformatf("rr_ack_%0d", i), 32'(r_ack), 1 << exp_r[i]);
        end
        req_wr = '0;
        repeat (3) tick();
        check("end_idle", 32'({f_busy, r_busy}), 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
